freq_div_prog: RTL and testbench
================================

Name: freq_div_prog

Overview:
- Parametrised programmable clock divider that generalises the fixed 16-tap power-of-two divider.
- Generates Fout from Fin in one of two modes:
  - power-of-two tap mode;
  - arbitrary integer-ratio mode, with near-50% duty cycle.
- Reconfiguration uses a Load/Busy handshake and applies only at a period boundary, so Fout never glitches or produces runt pulses.
- A free-running F_PFD tap feeds the PLL phase-frequency detector and is unaffected by reconfiguration.

Parameters:
- CNT_W, 17: output counter width. Maximum integer ratio is 2^CNT_W-1.
- SEL_W, 4: tap select width. Tap k gives Fin/2^(k+1), for k = 0..2^SEL_W-1.
- PFD_W, 6: prescaler width. F_PFD = prescaler[PFD_W-1], i.e. Fin/2^PFD_W.

Ports:
- Fin  input  1  clock; all state updates on its rising edge.
- Resetn  input  1  asynchronous active-low reset.
- Enable  input  1  run request for the Fout generator.
- Mode  input  1  0 = tap mode (uses Fsel); 1 = integer mode (uses Ndiv). Sampled on Load.
- Fsel  input  SEL_W  tap select. Sampled on Load.
- Ndiv  input  CNT_W  integer divide ratio. Sampled on Load.
- Load  input  1  single-cycle request to apply Mode/Fsel/Ndiv.
- Busy  output  1  high while a loaded configuration is pending.
- Fout  output  1  divided clock, registered.
- Tick  output  1  one-cycle pulse in the first cycle of each Fout period.
- F_PFD  output  1  free-running PFD reference, Fin/2^PFD_W.

Behaviour:
- Reset (Resetn=0, asynchronous): all outputs are 0.
  - prescaler=0, cnt=0, state=IDLE.
  - Active config: Mode=0, Fsel=0, giving Nact=2.
  - Stopped.
- Prescaler: PFD_W-bit free-running up-counter, wrap-around, increments every cycle from reset release.
  - F_PFD is registered prescaler MSB.
  - Ignores Enable and Load.
- Effective ratio, computed at Load time into shadow registers:
  - tap mode: N = 2^(Fsel+1);
  - integer mode: N = Ndiv, with Ndiv<2 clamped to 2.
  - H = ceil(N/2).
- Output generator while running:
  - cnt counts 0..Nact-1 and wraps to 0.
  - Fout is registered and equals (cnt<Hact), aligned with cnt.
  - Examples: N=5 gives high 3 / low 2; N=4 gives high 2 / low 2.
  - Tick=1 exactly when running and cnt==0.
- Period end: cycle with cnt==Nact-1. Fout is low there for every N≥2.
- Enable:
  - Rising while stopped: start on the next edge with cnt=0, so Fout=1 and Tick=1 in the first cycle after Enable is sampled high.
  - Falling while running: continue until the period end, then stop with cnt=0, Fout=0.
  - Enable reasserted before the period end cancels the stop, with no disturbance.
- Config FSM: IDLE, PENDING.
  - IDLE, Load=1: capture shadow N/H; Busy=1 from the next cycle; go to PENDING.
  - PENDING, period end or generator stopped: on that edge copy shadow to Nact/Hact and set cnt=0; Busy=0 on the following cycle; go to IDLE.
  - The new ratio takes effect on the first cycle of the next period (Fout high, Tick).
  - Load while Busy=1 is ignored: the shadow is not overwritten and there is no error.
  - Load and period end in the same cycle in IDLE: capture only; apply at the next period end, never in the same cycle.
  - Load while stopped: applies on the next edge; Busy pulses for one cycle.
- No runt rule: every Fout high phase lasts exactly Hact cycles and every low phase exactly Nact-Hact cycles of the config active in that period.
- Reset mid-operation: immediately returns everything to reset values; any pending config is discarded.

Test Plan:
- Reset release, Enable=1, default config:
  - Fout toggles every cycle (Fin/2), Tick every 2 cycles.
  - F_PFD period is 64 cycles, first rising edge at cycle 32.
  - Busy=0.
- Load Mode=0, Fsel=5 mid-period of N=2:
  - Busy high until the period end.
  - Fout then has a 64-cycle period, 32 high / 32 low, with no short pulse at the switch.
  - F_PFD phase is unchanged.
- Load Mode=1, Ndiv=5, then Ndiv=0 and Ndiv=1:
  - Ndiv=5 gives a 3-high / 2-low pattern repeating every 5 cycles.
  - Ndiv=0 and Ndiv=1 each behave as N=2.
- Load with N=7 active at cnt=1, second Load the next cycle with Ndiv=3:
  - The second Load is ignored.
  - The new N applies after cnt reaches 6.
  - Busy high for exactly the intervening cycles.
- Enable drop at cnt=1 of N=8:
  - Fout finishes the 4-high / 4-low period, then stays 0 with Tick=0.
  - Re-enable gives Fout=1 and Tick the next cycle.
- Resetn asserted mid-high-phase with Load pending:
  - Fout, Busy, Tick and F_PFD go 0 immediately.
  - After release the divide ratio is 2.

Source files
------------

// File: rtl/freq_div_prog.sv
// ---------------------------------------------------------------------------
// freq_div_prog
//
// Programmable clock divider. Fout is derived from Fin either as a
// power-of-two tap (Fin/2^(Fsel+1)) or as an arbitrary integer ratio Ndiv
// with near-50% duty cycle (high for ceil(N/2) cycles, then low for the
// rest). A new configuration is captured on Load into shadow registers and
// only becomes active at a period boundary, so Fout never produces a runt
// pulse. A separate free-running prescaler provides the PLL PFD reference.
//
// Parameters
//   CNT_W : output counter width, maximum integer ratio 2^CNT_W-1
//           (must be at least 2^SEL_W+1 so every tap ratio fits)
//   SEL_W : tap select width
//   PFD_W : prescaler width, F_PFD = Fin/2^PFD_W
//
// Ports
//   Fin    in   input clock, all state updates on its rising edge
//   Resetn in   asynchronous active-low reset
//   Enable in   run request for the Fout generator
//   Mode   in   0 = tap mode (Fsel), 1 = integer mode (Ndiv); sampled on Load
//   Fsel   in   tap select; sampled on Load
//   Ndiv   in   integer divide ratio; sampled on Load
//   Load   in   single-cycle request to apply Mode/Fsel/Ndiv
//   Busy   out  high while a captured configuration waits for a boundary
//   Fout   out  divided clock, registered
//   Tick   out  one-cycle pulse in the first cycle of every Fout period
//   F_PFD  out  free-running PFD reference, registered prescaler MSB
// ---------------------------------------------------------------------------
module freq_div_prog #(
    parameter int CNT_W = 17,
    parameter int SEL_W = 4,
    parameter int PFD_W = 6
) (
    input  logic             Fin,
    input  logic             Resetn,
    input  logic             Enable,
    input  logic             Mode,
    input  logic [SEL_W-1:0] Fsel,
    input  logic [CNT_W-1:0] Ndiv,
    input  logic             Load,
    output logic             Busy,
    output logic             Fout,
    output logic             Tick,
    output logic             F_PFD
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};
    localparam logic [PFD_W-1:0] PFD_ONE  = {{(PFD_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_e;

    // Effective divide ratio N for a requested configuration.
    function automatic logic [CNT_W-1:0] calc_n(
        input logic             mode,
        input logic [SEL_W-1:0] fsel,
        input logic [CNT_W-1:0] ndiv
    );
        logic [CNT_W-1:0] n_v;
        logic [SEL_W:0]   sh_v;
        n_v  = CNT_TWO;
        sh_v = {1'b0, fsel} + {{SEL_W{1'b0}}, 1'b1};
        if (mode) begin
            // Ratios 0 and 1 cannot form a high and a low phase; run them as 2.
            if (ndiv[CNT_W-1:1] == {(CNT_W-1){1'b0}}) begin
                n_v = CNT_TWO;
            end else begin
                n_v = ndiv;
            end
        end else begin
            n_v = CNT_ONE << sh_v;
        end
        return n_v;
    endfunction

    // High-phase length ceil(N/2), written so that N+1 never overflows.
    function automatic logic [CNT_W-1:0] calc_h(input logic [CNT_W-1:0] n);
        return (n >> 1) + {{(CNT_W-1){1'b0}}, n[0]};
    endfunction

    // Prescaler and PFD reference
    logic [PFD_W-1:0] pre_q, pre_d;
    logic             f_pfd_q, f_pfd_d;

    // Configuration FSM and shadow / active ratio registers
    cfg_state_e       cfg_state_q, cfg_state_d;
    logic [CNT_W-1:0] n_sh_q, n_sh_d;
    logic [CNT_W-1:0] h_sh_q, h_sh_d;
    logic [CNT_W-1:0] n_act_q, n_act_d;
    logic [CNT_W-1:0] h_act_q, h_act_d;

    // Output generator
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             fout_q, fout_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;

    // Combinational helpers
    logic [CNT_W-1:0] load_n_s;
    logic [CNT_W-1:0] load_h_s;
    logic [CNT_W-1:0] n_last_s;
    logic             period_end_s;

    assign load_n_s     = calc_n(Mode, Fsel, Ndiv);
    assign load_h_s     = calc_h(load_n_s);
    assign n_last_s     = n_act_q - CNT_ONE;
    assign period_end_s = run_q && (cnt_q == n_last_s);

    // Prescaler next state: free-running, independent of Enable and Load.
    always_comb begin
        pre_d   = pre_q + PFD_ONE;
        f_pfd_d = pre_d[PFD_W-1];
    end

    // Prescaler and F_PFD registers.
    always_ff @(posedge Fin or negedge Resetn) begin
        if (!Resetn) begin
            pre_q   <= {PFD_W{1'b0}};
            f_pfd_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            f_pfd_q <= f_pfd_d;
        end
    end

    // Config FSM: capture on Load, hand over to the generator at a boundary.
    always_comb begin
        cfg_state_d = cfg_state_q;
        n_sh_d      = n_sh_q;
        h_sh_d      = h_sh_q;
        n_act_d     = n_act_q;
        h_act_d     = h_act_q;
        case (cfg_state_q)
            CFG_IDLE: begin
                if (Load) begin
                    n_sh_d      = load_n_s;
                    h_sh_d      = load_h_s;
                    cfg_state_d = CFG_PENDING;
                end else begin
                    cfg_state_d = CFG_IDLE;
                end
            end
            CFG_PENDING: begin
                // Load is ignored here so the captured shadow stays intact.
                if (period_end_s || !run_q) begin
                    n_act_d     = n_sh_q;
                    h_act_d     = h_sh_q;
                    cfg_state_d = CFG_IDLE;
                end else begin
                    cfg_state_d = CFG_PENDING;
                end
            end
            default: begin
                cfg_state_d = CFG_IDLE;
            end
        endcase
    end

    // Generator: count 0..N-1, and only start or stop at a period boundary.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (run_q) begin
            if (period_end_s) begin
                // Enable is only looked at here, so a drop that is undone
                // before the boundary never disturbs the waveform.
                cnt_d = CNT_ZERO;
                run_d = Enable;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                run_d = 1'b1;
            end
        end else begin
            cnt_d = CNT_ZERO;
            run_d = Enable;
        end
    end

    // Output next state, derived from next count and next active high length
    // so the registered outputs line up with the counter.
    always_comb begin
        fout_d = run_d && (cnt_d < h_act_d);
        tick_d = run_d && (cnt_d == CNT_ZERO);
        busy_d = (cfg_state_d == CFG_PENDING);
    end

    // Config and generator state registers.
    always_ff @(posedge Fin or negedge Resetn) begin
        if (!Resetn) begin
            cfg_state_q <= CFG_IDLE;
            n_sh_q      <= CNT_TWO;
            h_sh_q      <= CNT_ONE;
            n_act_q     <= CNT_TWO;
            h_act_q     <= CNT_ONE;
            cnt_q       <= CNT_ZERO;
            run_q       <= 1'b0;
        end else begin
            cfg_state_q <= cfg_state_d;
            n_sh_q      <= n_sh_d;
            h_sh_q      <= h_sh_d;
            n_act_q     <= n_act_d;
            h_act_q     <= h_act_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge Fin or negedge Resetn) begin
        if (!Resetn) begin
            fout_q <= 1'b0;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            fout_q <= fout_d;
            tick_q <= tick_d;
            busy_q <= busy_d;
        end
    end

    assign Fout  = fout_q;
    assign Tick  = tick_q;
    assign Busy  = busy_q;
    assign F_PFD = f_pfd_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// ---------------------------------------------------------------------------
// tb_freq_div_prog
//
// Directed bench for freq_div_prog. The driver issues one input vector per
// Fin cycle and pushes the hand-derived expected {Fout, Tick, Busy, F_PFD}
// for the following rising edge into a queue; an independent monitor pops
// and compares one entry after every rising edge.
// ---------------------------------------------------------------------------
module tb_freq_div_prog;

    logic        Fin;
    logic        Resetn;
    logic        Enable;
    logic        Mode;
    logic [3:0]  Fsel;
    logic [16:0] Ndiv;
    logic        Load;
    logic        Busy;
    logic        Fout;
    logic        Tick;
    logic        F_PFD;

    int n_cmp;
    int n_bad;
    int edge_cnt;

    logic [3:0] exp_q[$];
    string      name_q[$];

    freq_div_prog #(
        .CNT_W(17),
        .SEL_W(4),
        .PFD_W(6)
    ) dut (
        .Fin   (Fin),
        .Resetn(Resetn),
        .Enable(Enable),
        .Mode  (Mode),
        .Fsel  (Fsel),
        .Ndiv  (Ndiv),
        .Load  (Load),
        .Busy  (Busy),
        .Fout  (Fout),
        .Tick  (Tick),
        .F_PFD (F_PFD)
    );

    initial begin
        Fin = 1'b0;
        forever #5 Fin = ~Fin;
    end

    task automatic check(input string nm, input string fld, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s at t=%0t: got %b expected %b", nm, fld, $time, got, exp);
        end
    endtask

    // One Fin cycle: drive inputs, queue the expectation for the next edge.
    task automatic cyc(input string nm, input logic en, input logic ld, input logic md,
                       input logic [3:0] fs, input logic [16:0] nd,
                       input logic ef, input logic et, input logic eb);
        logic ep;
        Enable = en;
        Load   = ld;
        Mode   = md;
        Fsel   = fs;
        Ndiv   = nd;
        edge_cnt++;
        ep = ((edge_cnt % 64) >= 32);
        exp_q.push_back({ef, et, eb, ep});
        name_q.push_back(nm);
        @(negedge Fin);
    endtask

    // Run cnt cycles of an N/H period starting at position k0 with Enable=1;
    // the optional Load is presented in the first cycle only.
    task automatic seg(input string nm, input int n, input int h, input int k0,
                       input int cnt, input logic eb, input logic ld = 1'b0,
                       input logic md = 1'b0, input logic [3:0] fs = 4'd0,
                       input logic [16:0] nd = 17'd0);
        for (int i = 0; i < cnt; i++) begin
            int k;
            k = (k0 + i) % n;
            cyc(nm, 1'b1, (i == 0) ? ld : 1'b0, md, fs, nd, k < h, k == 0, eb);
        end
    endtask

    // Monitor: compare one queued expectation after every rising edge.
    initial begin
        logic [3:0] e;
        string      nm;
        forever begin
            @(posedge Fin);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, "Fout",  Fout,  e[3]);
                check(nm, "Tick",  Tick,  e[2]);
                check(nm, "Busy",  Busy,  e[1]);
                check(nm, "F_PFD", F_PFD, e[0]);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: run did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        edge_cnt = 0;
        Resetn   = 1'b1;
        Enable   = 1'b0;
        Mode     = 1'b0;
        Fsel     = 4'd0;
        Ndiv     = 17'd0;
        Load     = 1'b0;
        #2 Resetn = 1'b0;
        repeat (3) @(negedge Fin);
        check("reset", "Fout",  Fout,  1'b0);
        check("reset", "Tick",  Tick,  1'b0);
        check("reset", "Busy",  Busy,  1'b0);
        check("reset", "F_PFD", F_PFD, 1'b0);

        // Default config N=2 from reset release; F_PFD rises at edge 32.
        Resetn = 1'b1;
        seg("a_default_n2", 2, 1, 0, 80, 1'b0);

        // Tap Fsel=5 loaded mid-period of N=2, Busy until the period end.
        seg("b_pre", 2, 1, 0, 1, 1'b0);
        seg("b_load_tap5", 2, 1, 1, 1, 1'b1, 1'b1, 1'b0, 4'd5, 17'd0);
        seg("b_n64", 64, 32, 0, 128, 1'b0);

        // Ndiv=5 loaded exactly at the period end: capture only.
        seg("c_load_at_end", 64, 32, 0, 64, 1'b1, 1'b1, 1'b1, 4'd0, 17'd5);
        seg("c_n5", 5, 3, 0, 10, 1'b0);

        // Ndiv=0 clamps to 2.
        seg("c_n5_pre", 5, 3, 0, 2, 1'b0);
        seg("c_load_nd0", 5, 3, 2, 3, 1'b1, 1'b1, 1'b1, 4'd0, 17'd0);
        seg("c_nd0_as_n2", 2, 1, 0, 6, 1'b0);

        // Back to 5, then Ndiv=1 clamps to 2.
        seg("c_load_nd5", 2, 1, 0, 2, 1'b1, 1'b1, 1'b1, 4'd0, 17'd5);
        seg("c_n5_again", 5, 3, 0, 5, 1'b0);
        seg("c_load_nd1", 5, 3, 0, 5, 1'b1, 1'b1, 1'b1, 4'd0, 17'd1);
        seg("c_nd1_as_n2", 2, 1, 0, 4, 1'b0);

        // N=7 active; Load Ndiv=4 at cnt=1, second Load Ndiv=3 ignored.
        seg("d_pre", 2, 1, 0, 1, 1'b0);
        seg("d_load_nd7", 2, 1, 1, 1, 1'b1, 1'b1, 1'b1, 4'd0, 17'd7);
        seg("d_n7", 7, 4, 0, 2, 1'b0);
        seg("d_load_nd4", 7, 4, 2, 1, 1'b1, 1'b1, 1'b1, 4'd0, 17'd4);
        seg("d_load_ignored", 7, 4, 3, 1, 1'b1, 1'b1, 1'b1, 4'd0, 17'd3);
        seg("d_n7_tail", 7, 4, 4, 3, 1'b1);
        seg("d_n4", 4, 2, 0, 8, 1'b0);

        // N=8, Enable dropped at cnt=1: finish the period then stop.
        seg("e_load_nd8", 4, 2, 0, 4, 1'b1, 1'b1, 1'b1, 4'd0, 17'd8);
        seg("e_n8", 8, 4, 0, 2, 1'b0);
        for (int k = 2; k < 8; k++) begin
            cyc("e_drop_finish", 1'b0, 1'b0, 1'b0, 4'd0, 17'd0, k < 4, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc("e_stopped", 1'b0, 1'b0, 1'b0, 4'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        end
        cyc("e_restart", 1'b1, 1'b0, 1'b0, 4'd0, 17'd0, 1'b1, 1'b1, 1'b0);
        seg("e_n8_run", 8, 4, 1, 7, 1'b0);

        // Enable dropped and restored before the period end: no effect.
        seg("e_cancel_pre", 8, 4, 0, 2, 1'b0);
        cyc("e_cancel_drop", 1'b0, 1'b0, 1'b0, 4'd0, 17'd0, 1'b1, 1'b0, 1'b0);
        cyc("e_cancel_drop", 1'b0, 1'b0, 1'b0, 4'd0, 17'd0, 1'b1, 1'b0, 1'b0);
        seg("e_cancel_run", 8, 4, 4, 12, 1'b0);

        // Load while stopped: Busy pulses one cycle, applies immediately.
        cyc("e_stop", 1'b0, 1'b0, 1'b0, 4'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        cyc("e_stopped_load", 1'b0, 1'b1, 1'b1, 4'd0, 17'd3, 1'b0, 1'b0, 1'b1);
        cyc("e_stopped_apply", 1'b0, 1'b0, 1'b0, 4'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        cyc("e_start_n3", 1'b1, 1'b0, 1'b0, 4'd0, 17'd0, 1'b1, 1'b1, 1'b0);
        seg("e_n3", 3, 2, 1, 5, 1'b0);

        // Reset during a high phase with a Load pending.
        seg("f_pre", 3, 2, 0, 1, 1'b0);
        cyc("f_load_nd9", 1'b1, 1'b1, 1'b1, 4'd0, 17'd9, 1'b1, 1'b0, 1'b1);
        Resetn = 1'b0;
        Load   = 1'b0;
        #1;
        check("f_reset_now", "Fout",  Fout,  1'b0);
        check("f_reset_now", "Tick",  Tick,  1'b0);
        check("f_reset_now", "Busy",  Busy,  1'b0);
        check("f_reset_now", "F_PFD", F_PFD, 1'b0);
        repeat (2) @(negedge Fin);
        Resetn   = 1'b1;
        edge_cnt = 0;
        seg("f_after_reset_n2", 2, 1, 0, 8, 1'b0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) begin
                @(negedge Fin);
            end
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
